tff_toggle_sequencer: RTL

Sequencer that drives the toggle input of a single T flip-flop with a programmed burst of toggle pulses. A burst is a pulse count and an inter-pulse gap, launched with a start/busy/done handshake. The block sits between a control source and one `tff` instance: its `t` output feeds the flop's `t`, and the flop's `q` returns on `q_fb` for expected-state tracking and optional readback checking.

---
 rtl/tff_toggle_sequencer_if.sv | 26 ++
 rtl/tff_toggle_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/tff_toggle_sequencer_if.sv
// Control-side bundle for tff_toggle_sequencer: burst launch handshake,
// burst parameters and status readback.
interface tff_toggle_sequencer_if #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
);
    logic             start;
    logic [CNT_W-1:0] toggles;
    logic [GAP_W-1:0] gap;
    logic             abort;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] issued;
    logic             expect_q;
    logic             err;

    modport master (
        output start, toggles, gap, abort,
        input  busy, done, issued, expect_q, err
    );

    modport slave (
        input  start, toggles, gap, abort,
        output busy, done, issued, expect_q, err
    );
endinterface

// File: rtl/tff_toggle_sequencer.sv
// Burst sequencer driving the t input of one T flip-flop.
// Define TFF_SEQ_READBACK_EN to build the q_fb readback checker.
module tff_toggle_sequencer #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    tff_toggle_sequencer_if.slave   ctl,
    input  logic                    q_fb,
    output logic                    t
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic             expq_q, expq_d;
    logic [CNT_W-1:0] issued_inc;

    assign issued_inc = issued_q + CNT_W'(1);

`ifdef TFF_SEQ_READBACK_EN
    logic chk_q, chk_d;
    logic err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        gcnt_d   = gcnt_q;
        issued_d = issued_q;
        expq_d   = expq_q;
`ifdef TFF_SEQ_READBACK_EN
        chk_d    = 1'b0;
        err_d    = err_q;
        // chk_q is only ever set leaving PULSE, so it never meets a start
        if (chk_q && (q_fb != expq_q)) begin
            err_d = 1'b1;
        end
`endif
        unique case (state_q)
            IDLE: begin
                if (ctl.start) begin
                    issued_d = '0;
                    if (ctl.toggles != '0) begin
                        cnt_d   = ctl.toggles;
                        gap_d   = ctl.gap;
                        expq_d  = q_fb;
                        state_d = PULSE;
`ifdef TFF_SEQ_READBACK_EN
                        err_d   = 1'b0;
`endif
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            PULSE: begin
                issued_d = issued_inc;
                expq_d   = ~expq_q;
`ifdef TFF_SEQ_READBACK_EN
                chk_d    = 1'b1;
`endif
                if (ctl.abort || (issued_inc == cnt_q)) begin
                    state_d = DONE;
                end else if (gap_q == '0) begin
                    state_d = PULSE;
                end else begin
                    gcnt_d  = gap_q - GAP_W'(1);
                    state_d = GAP;
                end
            end
            GAP: begin
                if (ctl.abort) begin
                    state_d = DONE;
                end else if (gcnt_q == '0) begin
                    state_d = PULSE;
                end else begin
                    gcnt_d = gcnt_q - GAP_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            gap_q    <= '0;
            gcnt_q   <= '0;
            issued_q <= '0;
            expq_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            gcnt_q   <= gcnt_d;
            issued_q <= issued_d;
            expq_q   <= expq_d;
        end
    end

`ifdef TFF_SEQ_READBACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            chk_q <= chk_d;
            err_q <= err_d;
        end
    end

    assign ctl.err = err_q;
`else
    assign ctl.err = 1'b0;
`endif

    assign t            = (state_q == PULSE);
    assign ctl.busy     = (state_q == PULSE) || (state_q == GAP);
    assign ctl.done     = (state_q == DONE);
    assign ctl.issued   = issued_q;
    assign ctl.expect_q = expq_q;

endmodule
